data_mem_bridge: RTL

- Sits directly downstream of the compute core's data-memory port: consumes MemEn/MemWrite/ByteEn/MemAdr/MemWriteData and returns MemReadData.
- Converts the core's single-cycle memory access into a registered valid/ready request plus valid response transaction on an external data bus.
- Holds the core with a combinational Stall until the response returns.
- Also provides a timeout watchdog and error reporting for bus faults.

---
 rtl/data_mem_bridge.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/data_mem_bridge.sv
// data_mem_bridge
// Turns the core's single-cycle data-memory access into one registered
// valid/ready request on the external data bus. The core is held on Stall
// until the matching response returns. A watchdog abandons accesses that
// take too long. Bus errors and timeouts are reported on Fault and FaultSticky.
//
// Ports
//   clk, reset          system clock (rising edge), synchronous active-high reset
//   MemEn/MemWrite      core access request and direction (1 = store)
//   ByteEn/MemAdr       byte lanes and byte address from the core
//   MemWriteData        lane-positioned store data
//   MemReadData         load data; valid only in the completion cycle, 0 for stores
//   Stall               hold the core; combinational so the issue cycle stalls too
//   Fault/FaultSticky   per-access failure pulse / failure flag held until reset
//   BusReq*             latched request towards the bus (address word aligned)
//   BusResp*            bus response; BusRespError qualifies BusRespValid
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no access outstanding; MemEn latches a new request
// ST_REQ     | BusReqValid high, waiting for BusReqReady
// ST_WAIT_RESP | request accepted, waiting for BusRespValid
// ST_DONE    | one cycle: result and Fault presented, Stall released
module data_mem_bridge #(
    parameter int BIT_COUNT      = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 MemEn,
    input  logic                 MemWrite,
    input  logic [3:0]           ByteEn,
    input  logic [BIT_COUNT-1:0] MemAdr,
    input  logic [31:0]          MemWriteData,
    output logic [31:0]          MemReadData,
    output logic                 Stall,
    output logic                 Fault,
    output logic                 FaultSticky,
    output logic                 BusReqValid,
    input  logic                 BusReqReady,
    output logic                 BusWrite,
    output logic [3:0]           BusByteEn,
    output logic [BIT_COUNT-1:0] BusAdr,
    output logic [31:0]          BusWriteData,
    input  logic                 BusRespValid,
    input  logic [31:0]          BusRespData,
    input  logic                 BusRespError
);

    generate
        if (BIT_COUNT != 32 && BIT_COUNT != 64) begin : g_bad_width
            $error("data_mem_bridge: BIT_COUNT must be 32 or 64");
        end
        if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
            $error("data_mem_bridge: TIMEOUT_CYCLES must be at least 2");
        end
    endgenerate

    // The counter never needs to hold more than TIMEOUT_CYCLES-1.
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_RESP,
        ST_DONE
    } state_t;

    state_t                state, state_next;
    logic [CW-1:0]         cnt, cnt_next;
    logic                  write_q;
    logic [3:0]            be_q;
    logic [BIT_COUNT-1:0]  adr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;
    logic                  err_q;
    logic                  sticky_q;

    logic                  timeout;
    logic                  finish;
    logic                  finish_err;
    logic [31:0]           finish_data;

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        finish      = 1'b0;
        finish_err  = 1'b0;
        finish_data = '0;
        timeout     = (cnt == CNT_LAST);
        case (state)
            ST_IDLE: begin
                if (MemEn) begin
                    state_next = ST_REQ;
                    cnt_next   = '0;
                end
            end
            ST_REQ: begin
                cnt_next = cnt + 1'b1;
                // Responses are meaningless before acceptance and are ignored here.
                // On the last allowed cycle the watchdog wins over a late accept.
                if (timeout) begin
                    state_next = ST_DONE;
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end else if (BusReqReady) begin
                    state_next = ST_WAIT_RESP;
                end
            end
            ST_WAIT_RESP: begin
                cnt_next = cnt + 1'b1;
                // A response on the timeout cycle still completes normally.
                if (BusRespValid) begin
                    state_next  = ST_DONE;
                    finish      = 1'b1;
                    finish_err  = BusRespError;
                    finish_data = write_q ? 32'h0 : BusRespData;
                end else if (timeout) begin
                    state_next = ST_DONE;
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            write_q  <= 1'b0;
            be_q     <= '0;
            adr_q    <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (state == ST_IDLE && MemEn) begin
                write_q <= MemWrite;
                be_q    <= ByteEn;
                adr_q   <= MemAdr & ~BIT_COUNT'(3);
                wdata_q <= MemWriteData;
            end
            if (finish) begin
                rdata_q <= finish_data;
                err_q   <= finish_err;
                if (finish_err) begin
                    sticky_q <= 1'b1;
                end
            end
        end
    end

    assign Stall        = (state == ST_IDLE) ? MemEn : (state != ST_DONE);
    assign BusReqValid  = (state == ST_REQ);
    assign BusWrite     = write_q;
    assign BusByteEn    = be_q;
    assign BusAdr       = adr_q;
    assign BusWriteData = wdata_q;
    assign MemReadData  = (state == ST_DONE) ? rdata_q : 32'h0;
    assign Fault        = (state == ST_DONE) && err_q;
    assign FaultSticky  = sticky_q;

endmodule
